// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two request/response ports
package alu_arbiter_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_X = 3'b111} alu_mode_t;
  typedef logic [31:0] word_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  alu_mode_t        req0_mode_i,
  input  word_t            req0_op1_i,
  input  word_t            req0_op2_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  alu_mode_t        req1_mode_i,
  input  word_t            req1_op1_i,
  input  word_t            req1_op2_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output word_t            rsp0_result_o,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output word_t            rsp1_result_o,
  output alu_mode_t        alu_mode_o,
  output word_t            alu_op1_o,
  output word_t            alu_op2_o,
  input  word_t            alu_result_async_i,
  output logic [CNT_W-1:0] conflict_count_o
);
  logic last_q, elig0, elig1, gnt0, gnt1;
  // a port is eligible only if its response slot is free or draining this cycle
  always_comb begin
    elig0 = reset_ni && req0_valid_i && (!rsp0_valid_o || rsp0_ready_i);
    elig1 = reset_ni && req1_valid_i && (!rsp1_valid_o || rsp1_ready_i);
    gnt0 = elig0 && (!elig1 || last_q);
    gnt1 = elig1 && !gnt0;
    req0_ready_o = gnt0;
    req1_ready_o = gnt1;
    alu_mode_o = gnt0 ? req0_mode_i : gnt1 ? req1_mode_i : ALU_X;
    alu_op1_o = gnt0 ? req0_op1_i : gnt1 ? req1_op1_i : '0;
    alu_op2_o = gnt0 ? req0_op2_i : gnt1 ? req1_op2_i : '0;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q <= 1'b1;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp0_result_o <= '0;
      rsp1_result_o <= '0;
      conflict_count_o <= '0;
    end else begin
      if (gnt0 || gnt1) last_q <= gnt1;
      if (gnt0) begin
        rsp0_valid_o <= 1'b1;
        rsp0_result_o <= alu_result_async_i;
      end else if (rsp0_ready_i) rsp0_valid_o <= 1'b0;
      if (gnt1) begin
        rsp1_valid_o <= 1'b1;
        rsp1_result_o <= alu_result_async_i;
      end else if (rsp1_ready_i) rsp1_valid_o <= 1'b0;
      if (elig0 && elig1 && !(&conflict_count_o)) conflict_count_o <= conflict_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a cycle-level reference model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  logic clk = 0, reset_ni = 0;
  logic v [2], rdy [2];
  alu_mode_t md [2];
  word_t a [2], b [2];
  logic rq0, rq1, rv0, rv1;
  word_t rr0, rr1, alu_a, alu_b, alu_r;
  alu_mode_t alu_m;
  logic [3:0] cnt;
  int total = 0, bad = 0;
  logic m_rv [2];
  word_t m_rr [2];
  int m_last = 1, m_cnt = 0, m_g = -1;

  always #5 clk = ~clk;

  function automatic word_t alu_fn(alu_mode_t m, word_t x, word_t y);
    case (m)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      default: return '0;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_m, alu_a, alu_b);

  alu_arbiter #(.CNT_W(4)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .req0_valid_i(v[0]), .req0_ready_o(rq0), .req0_mode_i(md[0]), .req0_op1_i(a[0]), .req0_op2_i(b[0]),
    .req1_valid_i(v[1]), .req1_ready_o(rq1), .req1_mode_i(md[1]), .req1_op1_i(a[1]), .req1_op2_i(b[1]),
    .rsp0_valid_o(rv0), .rsp0_ready_i(rdy[0]), .rsp0_result_o(rr0),
    .rsp1_valid_o(rv1), .rsp1_ready_i(rdy[1]), .rsp1_result_o(rr1),
    .alu_mode_o(alu_m), .alu_op1_o(alu_a), .alu_op2_o(alu_b), .alu_result_async_i(alu_r),
    .conflict_count_o(cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rv[0] = 0; m_rv[1] = 0; m_rr[0] = '0; m_rr[1] = '0;
    m_last = 1; m_cnt = 0; m_g = -1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy0"}, rq0, 0);
    chk({tag, "_rdy1"}, rq1, 0);
    chk({tag, "_mode"}, alu_m, ALU_X);
    chk({tag, "_op1"}, alu_a, 0);
    chk({tag, "_op2"}, alu_b, 0);
  endtask

  // one clock cycle: check current outputs against the model, then advance the model across the edge
  task automatic step();
    logic e [2];
    word_t res;
    #1;
    for (int n = 0; n < 2; n++) e[n] = v[n] && (!m_rv[n] || rdy[n]);
    m_g = (e[0] && e[1]) ? (m_last == 1 ? 0 : 1) : e[0] ? 0 : e[1] ? 1 : -1;
    chk("ready0", rq0, m_g == 0);
    chk("ready1", rq1, m_g == 1);
    chk("alu_mode", alu_m, m_g < 0 ? ALU_X : md[m_g]);
    chk("alu_op1", alu_a, m_g < 0 ? 0 : a[m_g]);
    chk("alu_op2", alu_b, m_g < 0 ? 0 : b[m_g]);
    chk("rsp0_valid", rv0, m_rv[0]);
    chk("rsp1_valid", rv1, m_rv[1]);
    if (m_rv[0]) chk("rsp0_result", rr0, m_rr[0]);
    if (m_rv[1]) chk("rsp1_result", rr1, m_rr[1]);
    chk("conflicts", cnt, m_cnt);
    res = m_g < 0 ? '0 : alu_fn(md[m_g], a[m_g], b[m_g]);
    @(posedge clk);
    for (int n = 0; n < 2; n++)
      if (m_g == n) begin m_rv[n] = 1; m_rr[n] = res; end
      else if (rdy[n]) m_rv[n] = 0;
    if (m_g >= 0) m_last = m_g;
    if (e[0] && e[1] && m_cnt < 15) m_cnt++;
    #1;
  endtask

  initial begin
    model_reset();
    v[0] = 1; v[1] = 1; rdy[0] = 1; rdy[1] = 1;
    md[0] = ALU_ADD; md[1] = ALU_OR; a[0] = 1; b[0] = 2; a[1] = 3; b[1] = 4;
    #2;
    chk_idle_outputs("in_reset");
    chk("reset_rv0", rv0, 0);
    chk("reset_rv1", rv1, 0);
    chk("reset_cnt", cnt, 0);
    @(posedge clk); #1;
    v[0] = 0; v[1] = 0;
    reset_ni = 1;
    step();
    // single port add
    v[0] = 1; md[0] = ALU_ADD; a[0] = 5; b[0] = 7;
    step();
    v[0] = 0;
    #1; chk("single_valid", rv0, 1); chk("single_result", rr0, 12);
    step();
    step();
    chk("single_cleared", rv0, 0);
    // contention, alternating grants
    v[0] = 1; md[0] = ALU_SUB; a[0] = 10; b[0] = 3;
    v[1] = 1; md[1] = ALU_XOR; a[1] = 32'hF0; b[1] = 32'hFF;
    for (int i = 0; i < 6; i++) step();
    chk("cont_r0", rr0, 7);
    chk("cont_r1", rr1, 32'h0F);
    // backpressure on port 0
    rdy[0] = 0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_hold", rr0, 7);
    rdy[0] = 1;
    #1; chk("bp_release_gnt", rq0, 1);
    step();
    // saturation of the conflict counter
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", cnt, 15);
    // asynchronous reset with a pending port-1 response
    v[0] = 0; v[1] = 1; rdy[1] = 0; md[1] = ALU_AND; a[1] = 32'hFF00; b[1] = 32'h0FF0;
    step();
    step();
    chk("pre_reset_rv1", rv1, 1);
    #2 reset_ni = 0;
    #1;
    chk("async_rv1", rv1, 0);
    chk("async_cnt", cnt, 0);
    chk_idle_outputs("async");
    model_reset();
    v[0] = 1; v[1] = 1; rdy[1] = 1;
    reset_ni = 1;
    #1; chk("post_reset_first", rq0, 1);
    step();
    // idle keeps the pointer: port 1 must win next contention
    v[0] = 0; v[1] = 0;
    step();
    step();
    v[0] = 1; v[1] = 1;
    #1; chk("idle_keeps_last", rq1, 1);
    step();
    // random traffic, requesters hold operands until accepted
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || m_g == n) begin
          v[n] = ($urandom_range(0, 3) != 0);
          md[n] = alu_mode_t'($urandom_range(0, 4));
          a[n] = $urandom;
          b[n] = $urandom;
        end
        rdy[n] = ($urandom_range(0, 9) < 7);
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
